fifo_rd_ctrl: RTL and testbench

Read-domain controller for the dual-clock FIFO. It owns the read pointer and compares it against the write pointer after that pointer has passed through the 2-flop synchronizer into rclk. It sequences reads from the 1-cycle-latency storage RAM and presents the data on a first-word-fall-through valid/ready interface. A 2-entry output buffer sustains 1 word/cycle despite the RAM latency. It also generates the empty, almost-empty and fill-level status.

---
 rtl/fifo_rd_ctrl_if.sv | 21 ++
 rtl/fifo_rd_ctrl.sv | 153 +++++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Consumer-side stream of the FIFO read controller: first-word-fall-through valid/ready.
// The master drives the valid flag and the data word; the slave drives ready.
interface fifo_rd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the dual-clock FIFO: read pointer, RAM read sequencing, 2-entry FWFT
// output buffer, and empty/almost-empty/level status. Optional flush input under FIFO_RD_FLUSH_EN.
module fifo_rd_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
`ifdef FIFO_RD_FLUSH_EN
  input  logic                  rflush,
`endif
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  ren,
  input  logic [DATA_WIDTH-1:0] rdata_mem,
  fifo_rd_ctrl_if.master        m_bus,
  output logic                  rempty,
  output logic                  raempty,
  output logic [ADDR_WIDTH+1:0] rlevel
);

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam logic [ADDR_WIDTH+1:0] AEmptyThresh = AEMPTY_THRESH[ADDR_WIDTH+1:0];

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = int'(ADDR_WIDTH) - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Pointer and status state
  ptr_t                  rbin_q, rbin_d;
  ptr_t                  rptr_q;
  ptr_t                  wbin;
  logic                  rempty_q, rempty_d;
  logic                  raempty_q, raempty_d;
  logic [ADDR_WIDTH+1:0] rlevel_q, rlevel_d;

  // Read pipeline and output buffer state
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic                  head_q;
  logic                  tail_idx;
  logic [DATA_WIDTH-1:0] obuf_q [2];

  logic                  m_valid;
  logic                  pop;
  logic                  push;
  logic                  flush;
  logic [2:0]            pend;

`ifdef FIFO_RD_FLUSH_EN
  assign flush = rflush;
`else
  assign flush = 1'b0;
`endif

  assign m_valid = (occ_q != 2'd0);
  assign pop     = m_valid & m_bus.m_ready & ~flush;
  assign push    = inflight_q & ~flush;

  // Words committed to the buffer after this cycle's pop; a new read may issue only if the
  // returning word is guaranteed a free slot.
  assign pend = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, m_valid & m_bus.m_ready};

  always_comb begin
    ren = 1'b0;
    if (!rempty_q && (pend < 3'd2) && !flush) begin
      ren = 1'b1;
    end
  end

  always_comb begin
    wbin       = gray2bin(rq2_wptr);
    rbin_d     = rbin_q + {{ADDR_WIDTH{1'b0}}, ren};
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    inflight_d = ren;
    rempty_d   = (bin2gray(rbin_d) == rq2_wptr);
    if (flush) begin
      rbin_d   = wbin;
      occ_d    = 2'd0;
      rempty_d = 1'b1;
    end
    rlevel_d  = {1'b0, ptr_t'(wbin - rbin_d)}
              + {{(ADDR_WIDTH + 1){1'b0}}, inflight_d}
              + {{ADDR_WIDTH{1'b0}}, occ_d};
    raempty_d = (rlevel_d <= AEmptyThresh);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      rempty_q   <= 1'b1;
      raempty_q  <= 1'b1;
      rlevel_q   <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= bin2gray(rbin_d);
      rempty_q   <= rempty_d;
      raempty_q  <= raempty_d;
      rlevel_q   <= rlevel_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
    end
  end

  // A push never meets a full buffer, so the tail is the head when empty, else the other slot.
  assign tail_idx = head_q ^ occ_q[0];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head_q    <= 1'b0;
      obuf_q[0] <= '0;
      obuf_q[1] <= '0;
    end else begin
      if (push) begin
        obuf_q[tail_idx] <= rdata_mem;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

  assign rptr          = rptr_q;
  assign raddr         = rbin_q[ADDR_WIDTH-1:0];
  assign rempty        = rempty_q;
  assign raempty       = raempty_q;
  assign rlevel        = rlevel_q;
  assign m_bus.m_valid = m_valid;
  assign m_bus.m_data  = obuf_q[head_q];

`ifndef SYNTHESIS
  a_no_read_when_empty : assert property (@(posedge rclk) disable iff (!rrst_n)
    !(ren && rempty_q));
  a_buffer_bound : assert property (@(posedge rclk) disable iff (!rrst_n)
    ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: RAM + write-pointer model, data scoreboard, table-driven
// status steps and hand-written latency, backpressure, almost-empty, wrap, flush and reset cases.
module tb_fifo_rd_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;

  typedef struct {
    int         nwr;
    logic       rdy;
    int         wait_cyc;
    int         exp_ren;
    logic [4:0] lvl;
    logic       emp;
    logic       aemp;
    logic       vld;
    logic [3:0] rp;
  } vec_t;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic [AW:0]   rq2_wptr;
  logic [AW:0]   rptr;
  logic [AW-1:0] raddr;
  logic          ren;
  logic [DW-1:0] rdata_mem = '0;
  logic          rempty;
  logic          raempty;
  logic [AW+1:0] rlevel;
  logic          rflush = 1'b0;

  fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_ctrl #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .AEMPTY_THRESH(4)
  ) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
`ifdef FIFO_RD_FLUSH_EN
    .rflush   (rflush),
`endif
    .rq2_wptr (rq2_wptr),
    .rptr     (rptr),
    .raddr    (raddr),
    .ren      (ren),
    .rdata_mem(rdata_mem),
    .m_bus    (bus),
    .rempty   (rempty),
    .raempty  (raempty),
    .rlevel   (rlevel)
  );

  always #5 rclk = ~rclk;

  logic [DW-1:0] mem [8];
  logic [3:0]    wbin;
  logic [3:0]    mr;
  logic [DW-1:0] exp_q [$];
  int            pop_cyc [$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            ren_cnt = 0;
  int            pop_cnt = 0;
  int            cyc = 0;
  int unsigned   next_id = 1;
  bit            saw_wrap = 1'b0;
  bit            rec_pops = 1'b0;

  always @(posedge rclk) begin
    if (ren) rdata_mem <= mem[raddr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic push_words(input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = 32'hA5A5_0000 + DW'(next_id);
      next_id++;
      mem[wbin[2:0]] = d;
      exp_q.push_back(d);
      wbin = wbin + 4'd1;
    end
    rq2_wptr = g(wbin);
  endtask

  task automatic check_status(input string tag, input logic [4:0] lvl, input logic emp,
                              input logic aemp, input logic vld, input logic [3:0] rp);
    check({tag, "_rlevel"}, rlevel, lvl);
    check({tag, "_rempty"}, rempty, emp);
    check({tag, "_raempty"}, raempty, aemp);
    check({tag, "_m_valid"}, bus.m_valid, vld);
    check({tag, "_rptr"}, rptr, rp);
  endtask

  // Monitor: samples just before each rising edge and scores reads and handshakes.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge rclk);
      #4;
      if (rrst_n) begin
        cyc++;
        if (ren) begin
          check("ren_while_empty", rempty, 1'b0);
          check("raddr", raddr, mr[2:0]);
          mr = mr + 4'd1;
          ren_cnt++;
        end
        if (prev_stall) begin
          check("hold_valid", bus.m_valid, 1'b1);
          check("hold_data", bus.m_data, prev_data);
        end
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_word: got %0h expected no word", bus.m_data);
          end else begin
            check("m_data", bus.m_data, exp_q.pop_front());
          end
          pop_cnt++;
          if (rec_pops) pop_cyc.push_back(cyc);
        end
        if (rptr == 4'b1100) saw_wrap = 1'b1;
        prev_stall = bus.m_valid && !bus.m_ready && !rflush;
        prev_data  = bus.m_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs [6];
    int         r0;
    int         p0;
    int         wr;
    logic [3:0] base;
    bit         got;

    vecs[0] = '{nwr: 4, rdy: 1'b0, wait_cyc: 8,  exp_ren: 2, lvl: 5'd4, emp: 1'b0, aemp: 1'b1,
                vld: 1'b1, rp: 4'b0010};
    vecs[1] = '{nwr: 1, rdy: 1'b0, wait_cyc: 5,  exp_ren: 0, lvl: 5'd5, emp: 1'b0, aemp: 1'b0,
                vld: 1'b1, rp: 4'b0010};
    vecs[2] = '{nwr: 0, rdy: 1'b1, wait_cyc: 10, exp_ren: 3, lvl: 5'd0, emp: 1'b1, aemp: 1'b1,
                vld: 1'b0, rp: 4'b0101};
    vecs[3] = '{nwr: 7, rdy: 1'b0, wait_cyc: 6,  exp_ren: 2, lvl: 5'd7, emp: 1'b0, aemp: 1'b0,
                vld: 1'b1, rp: 4'b1100};
    vecs[4] = '{nwr: 1, rdy: 1'b0, wait_cyc: 3,  exp_ren: 0, lvl: 5'd8, emp: 1'b0, aemp: 1'b0,
                vld: 1'b1, rp: 4'b1100};
    vecs[5] = '{nwr: 0, rdy: 1'b1, wait_cyc: 14, exp_ren: 6, lvl: 5'd0, emp: 1'b1, aemp: 1'b1,
                vld: 1'b0, rp: 4'b1001};

    wbin        = '0;
    mr          = '0;
    rq2_wptr    = '0;
    bus.m_ready = 1'b0;
    rrst_n      = 1'b0;
    repeat (3) @(negedge rclk);
    rrst_n = 1'b1;

    // Reset state and idle with an empty write pointer
    check_status("reset", 5'd0, 1'b1, 1'b1, 1'b0, 4'b0000);
    check("reset_m_data", bus.m_data, 32'h0);
    repeat (10) @(negedge rclk);
    check("reset_no_ren", ren_cnt, 0);

    // Single word: status latency and first-word-fall-through
    @(negedge rclk);
    push_words(1);
    @(posedge rclk);
    #1;
    check("single_rempty_fall", rempty, 1'b0);
    check("single_ren", ren, 1'b1);
    check("single_raddr", raddr, 3'd0);
    check("single_valid_early", bus.m_valid, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(posedge rclk);
      #1;
      got = bus.m_valid;
    end
    check("single_valid", got, 1'b1);
    check("single_data", bus.m_data, 32'hA5A5_0001);
    @(negedge rclk);
    bus.m_ready = 1'b1;
    @(negedge rclk);
    bus.m_ready = 1'b0;
    check_status("single_after", 5'd0, 1'b1, 1'b1, 1'b0, 4'b0001);

    // Table-driven settled-status steps (crosses the pointer wrap)
    foreach (vecs[i]) begin
      @(negedge rclk);
      bus.m_ready = vecs[i].rdy;
      push_words(vecs[i].nwr);
      r0 = ren_cnt;
      repeat (vecs[i].wait_cyc) @(negedge rclk);
      check($sformatf("vec%0d_ren_count", i), ren_cnt - r0, vecs[i].exp_ren);
      check_status($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].emp, vecs[i].aemp,
                   vecs[i].vld, vecs[i].rp);
    end

    // Backpressure: two reads only, then four back-to-back pops with falling level
    @(negedge rclk);
    bus.m_ready = 1'b0;
    base = wbin;
    push_words(4);
    r0 = ren_cnt;
    repeat (6) @(negedge rclk);
    check("bp_ren_count", ren_cnt - r0, 2);
    check("bp_rptr", rptr, g(base + 4'd2));
    check("bp_rlevel", rlevel, 5'd4);
    bus.m_ready = 1'b1;
    p0 = pop_cnt;
    for (int k = 0; k < 4; k++) begin
      @(negedge rclk);
      check($sformatf("bp_drain_level%0d", k), rlevel, 5'(3 - k));
    end
    check("bp_pops", pop_cnt - p0, 4);
    bus.m_ready = 1'b0;

    // Almost-empty threshold crossing on a single pop
    @(negedge rclk);
    push_words(5);
    repeat (6) @(negedge rclk);
    check("ae_rlevel5", rlevel, 5'd5);
    check("ae_raempty5", raempty, 1'b0);
    bus.m_ready = 1'b1;
    @(negedge rclk);
    bus.m_ready = 1'b0;
    check("ae_rlevel4", rlevel, 5'd4);
    check("ae_raempty4", raempty, 1'b1);
    bus.m_ready = 1'b1;
    repeat (8) @(negedge rclk);
    bus.m_ready = 1'b0;
    check("ae_drained", rlevel, 5'd0);

    // Streaming 20 words through the wrap at one word per cycle
    @(negedge rclk);
    saw_wrap = 1'b0;
    pop_cyc.delete();
    rec_pops = 1'b1;
    p0 = pop_cnt;
    bus.m_ready = 1'b1;
    push_words(8);
    wr = 8;
    for (int t = 0; t < 200 && (pop_cnt - p0) < 20; t++) begin
      @(negedge rclk);
      if (wr < 20 && (wr - (pop_cnt - p0)) < 8) begin
        push_words(1);
        wr++;
      end
    end
    rec_pops = 1'b0;
    bus.m_ready = 1'b0;
    check("stream_pops", pop_cnt - p0, 20);
    if (pop_cyc.size() == 20) check("stream_span", pop_cyc[19] - pop_cyc[0], 19);
    else check("stream_span_count", pop_cyc.size(), 20);
    check("stream_saw_gray8", saw_wrap, 1'b1);

`ifdef FIFO_RD_FLUSH_EN
    // Flush with two buffered words and four unread in RAM
    @(negedge rclk);
    push_words(6);
    repeat (6) @(negedge rclk);
    check("fl_pre_valid", bus.m_valid, 1'b1);
    rflush = 1'b1;
    exp_q.delete();
    mr = wbin;
    @(negedge rclk);
    rflush = 1'b0;
    check_status("fl_after", 5'd0, 1'b1, 1'b1, 1'b0, g(wbin));
    push_words(2);
    bus.m_ready = 1'b1;
    p0 = pop_cnt;
    repeat (8) @(negedge rclk);
    bus.m_ready = 1'b0;
    check("fl_post_pops", pop_cnt - p0, 2);
`endif

    // Reset in the middle of buffered traffic
    @(negedge rclk);
    push_words(3);
    repeat (4) @(negedge rclk);
    rrst_n = 1'b0;
    #1;
    check_status("midrst", 5'd0, 1'b1, 1'b1, 1'b0, 4'b0000);
    exp_q.delete();
    wbin     = '0;
    mr       = '0;
    rq2_wptr = '0;
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
    push_words(1);
    bus.m_ready = 1'b1;
    p0 = pop_cnt;
    repeat (6) @(negedge rclk);
    bus.m_ready = 1'b0;
    check("midrst_pops", pop_cnt - p0, 1);
    check("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
